// File: rtl/sensor_pkg.sv
// Shared constants, state encoding and frame helpers for the sensor framing stage.
package sensor_pkg;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
  localparam int         FRAME_LEN      = 5;

  localparam logic [2:0] IDX_HDR   = 3'd0;
  localparam logic [2:0] IDX_SEQ   = 3'd1;
  localparam logic [2:0] IDX_TEMP  = 3'd2;
  localparam logic [2:0] IDX_LIGHT = 3'd3;
  localparam logic [2:0] IDX_CHK   = 3'(FRAME_LEN - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  function automatic logic [7:0] frame_chk(input logic [7:0] hdr, input logic [7:0] seq,
                                           input logic [7:0] temp, input logic [7:0] light);
    return hdr ^ seq ^ temp ^ light;
  endfunction

  // Selects the frame byte at position idx from the captured snapshot.
  function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [7:0] hdr,
                                            input logic [7:0] seq, input logic [7:0] temp,
                                            input logic [7:0] light, input logic [7:0] chk);
    logic [7:0] b;
    case (idx)
      IDX_HDR:   b = hdr;
      IDX_SEQ:   b = seq;
      IDX_TEMP:  b = temp;
      IDX_LIGHT: b = light;
      default:   b = chk;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Sample-tick divider: one tick every SAMPLE_DIV cycles while enabled, held at zero otherwise.
module tick_gen #(
  parameter int SAMPLE_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

  logic [CW-1:0] tick_cnt;

  assign tick = enable && (tick_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (!enable || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sensor_frame_tx.sv
// Snapshots temperature/light on each sample tick and streams a 5-byte checksummed
// frame to the UART TX over valid/ready; ticks arriving mid-frame are counted as overruns.
module sensor_frame_tx
  import sensor_pkg::*;
#(
  parameter int         SAMPLE_DIV = 100000,
  parameter logic [7:0] HEADER     = HEADER_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] temp_in,
  input  logic [7:0] light_in,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       frame_done,
  output logic [7:0] overrun_cnt
);

  logic tick;

  tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .tick   (tick)
  );

  state_t     state, state_next;
  logic [2:0] byte_idx, byte_idx_next;
  logic [7:0] seq, seq_next;
  logic [7:0] snap_temp, snap_temp_next;
  logic [7:0] snap_light, snap_light_next;
  logic [7:0] snap_chk, snap_chk_next;
  logic [7:0] tx_data_next;
  logic       tx_valid_next;
  logic       frame_done_next;
  logic [7:0] overrun_next;
  logic       fire;
  logic [2:0] idx_inc;

  assign fire    = tx_valid && tx_ready;
  assign idx_inc = byte_idx + 3'd1;

  always_comb begin
    state_next      = state;
    byte_idx_next   = byte_idx;
    seq_next        = seq;
    snap_temp_next  = snap_temp;
    snap_light_next = snap_light;
    snap_chk_next   = snap_chk;
    tx_data_next    = tx_data;
    tx_valid_next   = tx_valid;
    frame_done_next = 1'b0;
    overrun_next    = overrun_cnt;

    case (state)
      IDLE: begin
        if (tick) begin
          snap_temp_next  = temp_in;
          snap_light_next = light_in;
          snap_chk_next   = frame_chk(HEADER, seq, temp_in, light_in);
          byte_idx_next   = IDX_HDR;
          tx_data_next    = HEADER;
          tx_valid_next   = 1'b1;
          state_next      = SEND;
        end
      end
      SEND: begin
        // A tick here is dropped even on the cycle of the final transfer.
        if (tick && overrun_cnt != 8'hFF) begin
          overrun_next = overrun_cnt + 8'd1;
        end
        if (fire) begin
          if (byte_idx == IDX_CHK) begin
            state_next      = IDLE;
            tx_valid_next   = 1'b0;
            tx_data_next    = 8'h00;
            seq_next        = seq + 8'd1;
            frame_done_next = 1'b1;
          end else begin
            byte_idx_next = idx_inc;
            tx_data_next  = frame_byte(idx_inc, HEADER, seq, snap_temp, snap_light, snap_chk);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      byte_idx    <= IDX_HDR;
      seq         <= 8'h00;
      snap_temp   <= 8'h00;
      snap_light  <= 8'h00;
      snap_chk    <= 8'h00;
      tx_data     <= 8'h00;
      tx_valid    <= 1'b0;
      frame_done  <= 1'b0;
      overrun_cnt <= 8'h00;
    end else begin
      state       <= state_next;
      byte_idx    <= byte_idx_next;
      seq         <= seq_next;
      snap_temp   <= snap_temp_next;
      snap_light  <= snap_light_next;
      snap_chk    <= snap_chk_next;
      tx_data     <= tx_data_next;
      tx_valid    <= tx_valid_next;
      frame_done  <= frame_done_next;
      overrun_cnt <= overrun_next;
    end
  end

endmodule

// File: tb/tb_sensor_frame_tx.sv
// Bench for sensor_frame_tx: table-driven frames, hand-written corner sequences and a
// per-cycle behavioural model for two divider settings.
module tb_sensor_frame_tx;

  localparam logic [7:0] HDR = 8'hA5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       enable_a, ready_a, valid_a, done_a;
  logic [7:0] temp_a, light_a, data_a, ovr_a;
  logic       enable_b, ready_b, valid_b, done_b;
  logic [7:0] temp_b, light_b, data_b, ovr_b;

  sensor_frame_tx #(.SAMPLE_DIV(8)) dut_a (
    .clk(clk), .rst(rst), .enable(enable_a), .temp_in(temp_a), .light_in(light_a),
    .tx_data(data_a), .tx_valid(valid_a), .tx_ready(ready_a), .frame_done(done_a),
    .overrun_cnt(ovr_a)
  );

  sensor_frame_tx #(.SAMPLE_DIV(2)) dut_b (
    .clk(clk), .rst(rst), .enable(enable_b), .temp_in(temp_b), .light_in(light_b),
    .tx_data(data_b), .tx_valid(valid_b), .tx_ready(ready_b), .frame_done(done_b),
    .overrun_cnt(ovr_b)
  );

  int n_total = 0;
  int n_pass  = 0;
  bit chk_on  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: a frame is a 40-bit image built at capture, popped one byte per handshake.
  typedef struct packed {
    logic [31:0] cnt;
    logic        busy;
    logic [2:0]  idx;
    logic [7:0]  seq;
    logic [39:0] frame;
    logic [7:0]  ovr;
    logic        done;
  } model_t;

  function automatic logic [7:0] mbyte(input model_t m);
    return m.frame[39 - 8*int'(m.idx) -: 8];
  endfunction

  function automatic model_t mstep(input model_t m, input logic en, input logic rdy,
                                   input logic [7:0] t, input logic [7:0] l, input int div);
    model_t n;
    logic tk, fire;
    n    = m;
    tk   = en && (m.cnt == 32'(div - 1));
    fire = m.busy && rdy;
    n.cnt  = (!en || tk) ? 32'd0 : m.cnt + 32'd1;
    n.done = fire && (m.idx == 3'd4);
    if (fire) begin
      if (m.idx == 3'd4) begin
        n.busy = 1'b0;
        n.seq  = m.seq + 8'd1;
      end else begin
        n.idx = m.idx + 3'd1;
      end
    end
    if (tk) begin
      if (m.busy) begin
        if (m.ovr != 8'hFF) n.ovr = m.ovr + 8'd1;
      end else begin
        n.busy  = 1'b1;
        n.idx   = 3'd0;
        n.frame = {HDR, m.seq, t, l, HDR ^ m.seq ^ t ^ l};
      end
    end
    return n;
  endfunction

  model_t ma, mb;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma <= '0;
      mb <= '0;
    end else begin
      ma <= mstep(ma, enable_a, ready_a, temp_a, light_a, 8);
      mb <= mstep(mb, enable_b, ready_b, temp_b, light_b, 2);
    end
  end

  always @(negedge clk) begin
    if (chk_on && !rst) begin
      check("model_valid_a", valid_a, ma.busy);
      if (ma.busy) check("model_data_a", data_a, mbyte(ma));
      check("model_done_a", done_a, ma.done);
      check("model_ovr_a", ovr_a, ma.ovr);
      check("model_valid_b", valid_b, mb.busy);
      if (mb.busy) check("model_data_b", data_b, mbyte(mb));
      check("model_done_b", done_b, mb.done);
      check("model_ovr_b", ovr_b, mb.ovr);
    end
  end

  typedef struct {
    logic [7:0]  t;
    logic [7:0]  l;
    int          stall;
    logic [39:0] exp;
  } vec_t;

  vec_t tbl[4];

  function automatic logic [7:0] ebyte(input logic [39:0] f, input int k);
    return f[39 - 8*k -: 8];
  endfunction

  task automatic wait_valid_a(output bit ok);
    int w = 0;
    while (!valid_a && w < 40) begin
      @(negedge clk);
      w++;
    end
    ok = valid_a;
  endtask

  task automatic wait_valid_b(output bit ok);
    int w = 0;
    while (!valid_b && w < 40) begin
      @(negedge clk);
      w++;
    end
    ok = valid_b;
  endtask

  initial begin
    bit         ok;
    bit         seen_done;
    int         vcnt;
    logic [7:0] o0;
    logic [39:0] exp_b;

    tbl[0] = '{8'h19, 8'h96, -1, 40'hA5_00_19_96_2A};
    tbl[1] = '{8'h14, 8'h0A,  1, 40'hA5_01_14_0A_BA};
    tbl[2] = '{8'h33, 8'h44, -1, 40'hA5_02_33_44_D0};
    tbl[3] = '{8'hFF, 8'h00, -1, 40'hA5_03_FF_00_59};

    enable_a = 1'b0; ready_a = 1'b1; temp_a = 8'h00; light_a = 8'h00;
    enable_b = 1'b0; ready_b = 1'b0; temp_b = 8'h00; light_b = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    enable_a = 1'b1;
    temp_a   = tbl[0].t;
    light_a  = tbl[0].l;
    #2 rst = 1'b0;
    chk_on = 1'b1;

    @(negedge clk);
    check("reset_valid", valid_a, 1'b0);
    check("reset_done", done_a, 1'b0);
    check("reset_ovr", ovr_a, 8'h00);

    // Table-driven frames, entry 1 stalls three cycles on the seq byte.
    for (int i = 0; i < 4; i++) begin
      temp_a  = tbl[i].t;
      light_a = tbl[i].l;
      wait_valid_a(ok);
      check($sformatf("frame%0d_start", i), ok, 1'b1);
      for (int k = 0; k < 5; k++) begin
        if (k == tbl[i].stall) begin
          ready_a = 1'b0;
          temp_a  = ~temp_a;
          light_a = ~light_a;
          for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            check("stall_valid", valid_a, 1'b1);
            check("stall_data", data_a, ebyte(tbl[i].exp, k));
          end
          ready_a = 1'b1;
        end
        check($sformatf("frame%0d_valid%0d", i, k), valid_a, 1'b1);
        check($sformatf("frame%0d_byte%0d", i, k), data_a, ebyte(tbl[i].exp, k));
        @(negedge clk);
      end
      check($sformatf("frame%0d_done", i), done_a, 1'b1);
      @(negedge clk);
      check($sformatf("frame%0d_done_once", i), done_a, 1'b0);
    end

    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      enable_a = ($urandom_range(0, 15) != 0);
      ready_a  = ($urandom_range(0, 3) != 0);
      temp_a   = 8'($urandom);
      light_a  = 8'($urandom);
    end
    ready_a  = 1'b1;
    enable_a = 1'b1;
    @(negedge clk);

    // Dropping enable mid-frame lets the frame finish and stops further ticks.
    wait_valid_a(ok);
    check("en_frame_start", ok, 1'b1);
    enable_a  = 1'b0;
    seen_done = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done_a) seen_done = 1'b1;
    end
    check("en_frame_completes", seen_done, 1'b1);
    check("en_idle", valid_a, 1'b0);
    vcnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (valid_a) vcnt++;
    end
    check("en_no_tick", vcnt, 0);

    // Reset mid-frame aborts at once and restarts the sequence at zero.
    enable_a = 1'b1;
    wait_valid_a(ok);
    check("rst_frame_start", ok, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_valid_now", valid_a, 1'b0);
    check("rst_data_now", data_a, 8'h00);
    check("rst_ovr_now", ovr_a, 8'h00);
    @(negedge clk);
    #2 rst = 1'b0;
    wait_valid_a(ok);
    check("rst_next_start", ok, 1'b1);
    check("rst_next_hdr", data_a, HDR);
    @(negedge clk);
    check("rst_next_seq", data_a, 8'h00);

    // Overrun saturation on the fast-divider instance under a long stall.
    temp_b   = 8'h12;
    light_b  = 8'h34;
    ready_b  = 1'b0;
    enable_b = 1'b1;
    wait_valid_b(ok);
    check("ovr_frame_start", ok, 1'b1);
    @(negedge clk);
    o0 = ovr_b;
    repeat (2) @(negedge clk);
    check("ovr_step", ovr_b, 32'(o0) + 32'd1);
    temp_b  = 8'hEE;
    light_b = 8'hEE;
    repeat (600) @(negedge clk);
    check("ovr_saturated", ovr_b, 8'hFF);
    check("ovr_hold_valid", valid_b, 1'b1);
    check("ovr_hold_data", data_b, HDR);
    ready_b = 1'b1;
    exp_b   = 40'hA5_00_12_34_83;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("ovr_frame_byte%0d", k), data_b, ebyte(exp_b, k));
      @(negedge clk);
    end
    check("ovr_frame_done", done_b, 1'b1);
    @(negedge clk);
    check("ovr_still_saturated", ovr_b, 8'hFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
